// File: rtl/drac_pkg.sv
// ----------------------------------------------------------------------------
// drac_pkg
// Shared definitions for the dcache request tracker:
//   - drac_state_e      : fence FSM states (RUN / DRAIN / ACK)
//   - DRAC_TID_WIDTH    : default transaction-ID width (table holds 2**W tags)
//   - DRAC_MAX_INFLIGHT : default limit on outstanding dcache requests
// ----------------------------------------------------------------------------
package drac_pkg;

   localparam int DRAC_TID_WIDTH    = 7;
   localparam int DRAC_MAX_INFLIGHT = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,   // normal issue
      DRAIN = 2'd1,   // fence seen: no issue, wait for table and write buffer to empty
      ACK   = 2'd2    // one-cycle fence acknowledge
   } drac_state_e;

endpackage

// File: rtl/dcache_tag_table.sv
// ----------------------------------------------------------------------------
// dcache_tag_table
// One pending bit per transaction ID. A set marks a tag as outstanding, a
// clear retires it. Both take effect on the next clock edge.
//
// Ports
//   clk_i       in   clock
//   rstn_i      in   asynchronous active-low reset (clears every tag)
//   set_i       in   mark set_tid_i pending
//   set_tid_i   in   tag to mark
//   clr_i       in   retire clr_tid_i
//   clr_tid_i   in   tag to retire
//   pending_o   out  registered pending vector, bit n = tag n outstanding
// ----------------------------------------------------------------------------
module dcache_tag_table
   import drac_pkg::*;
#(
   parameter int TID_WIDTH = DRAC_TID_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      set_i,
   input  logic [TID_WIDTH-1:0]      set_tid_i,
   input  logic                      clr_i,
   input  logic [TID_WIDTH-1:0]      clr_tid_i,
   output logic [(2**TID_WIDTH)-1:0] pending_o
);

   localparam int NUM_TAGS = 2**TID_WIDTH;

   logic [NUM_TAGS-1:0] r_pending;

   // NOTE: this table is a flop vector rather than a RAM macro, so it can and
   // must be cleared by the asynchronous reset; a RAM would need a sweep.
   // NOTE: sequential state uses non-blocking assignments so every reader in
   // the same edge sees the pre-edge value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pending <= '0;
      end else begin
         // A tag can only be set while idle and cleared while pending, so the
         // two never target the same bit in one cycle.
         if (clr_i) r_pending[clr_tid_i] <= 1'b0;
         if (set_i) r_pending[set_tid_i] <= 1'b1;
      end
   end

   assign pending_o = r_pending;

endmodule

// File: rtl/dcache_req_tracker.sv
// ----------------------------------------------------------------------------
// dcache_req_tracker
// Gates core load/store requests onto the dcache, tracking each outstanding
// transaction ID so that a tag is never reused before its response returns
// and the number of outstanding requests never exceeds MAX_INFLIGHT. A fence
// handshake stops issue, waits for all responses and an empty write buffer,
// then acknowledges with a one-cycle pulse.
//
// Optional feature: define DCACHE_REQ_TRACKER_ERR_EN to enable the sticky
// orphan-response error flag; otherwise err_orphan_rsp_o is tied to 0.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   req_valid_i/_tid_i   core request and its transaction ID
//   req_is_store_i       request is a store (selects the PMU pulse)
//   req_ready_o          core request accepted this cycle
//   dc_req_valid_o       request presented to the dcache
//   dc_req_ready_i       dcache can accept a request
//   dc_rsp_valid_i/_tid_i dcache response and its transaction ID
//   wbuf_empty_i         write buffer is empty
//   fence_req_i          fence request (level, held until fence_ack_o)
//   fence_ack_o          fence complete (one-cycle pulse)
//   inflight_o           number of outstanding dcache requests
//   busy_o               fence in progress or requests outstanding
//   load_sent_o          pulse per load sent to the dcache
//   store_sent_o         pulse per store sent to the dcache
//   err_orphan_rsp_o     sticky: response seen for a tag that was not pending
// ----------------------------------------------------------------------------
module dcache_req_tracker
   import drac_pkg::*;
#(
   parameter int TID_WIDTH    = DRAC_TID_WIDTH,
   parameter int MAX_INFLIGHT = DRAC_MAX_INFLIGHT,
   parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   // core request
   input  logic                 req_valid_i,
   input  logic [TID_WIDTH-1:0] req_tid_i,
   input  logic                 req_is_store_i,
   output logic                 req_ready_o,
   // dcache request
   output logic                 dc_req_valid_o,
   input  logic                 dc_req_ready_i,
   // dcache response
   input  logic                 dc_rsp_valid_i,
   input  logic [TID_WIDTH-1:0] dc_rsp_tid_i,
   // write buffer
   input  logic                 wbuf_empty_i,
   // fence handshake
   input  logic                 fence_req_i,
   output logic                 fence_ack_o,
   // status
   output logic [CNT_WIDTH-1:0] inflight_o,
   output logic                 busy_o,
   // PMU
   output logic                 load_sent_o,
   output logic                 store_sent_o,
   // error
   output logic                 err_orphan_rsp_o
);

   drac_state_e                 r_state;
   logic                        r_fence_ack;
   logic [CNT_WIDTH-1:0]        r_inflight;

   logic [(2**TID_WIDTH)-1:0]   w_pending;
   logic                        w_run;
   logic                        w_slot_free;
   logic                        w_issue_ok;
   logic                        w_send;
   logic                        w_rsp_match;

   // ------------------------------------------------------------------------
   // Issue gating. Everything here comes from registered state, so a tag or
   // counter slot freed by a response this cycle is only reusable next cycle.
   // The fence input also blocks issue in the cycle the FSM leaves RUN, and
   // rstn_i blocks it while reset holds the table empty.
   // ------------------------------------------------------------------------
   assign w_run       = (r_state == RUN);
   assign w_slot_free = (r_inflight < CNT_WIDTH'(MAX_INFLIGHT));
   assign w_issue_ok  = w_run & ~fence_req_i & ~w_pending[req_tid_i] &
                        w_slot_free & rstn_i;

   assign dc_req_valid_o = req_valid_i & w_issue_ok;
   assign req_ready_o    = dc_req_ready_i & w_issue_ok;
   assign w_send         = dc_req_valid_o & dc_req_ready_i;

   // Only responses to a pending tag retire anything; orphans are ignored,
   // which keeps the counter from underflowing.
   assign w_rsp_match    = dc_rsp_valid_i & w_pending[dc_rsp_tid_i];

   assign load_sent_o    = w_send & ~req_is_store_i;
   assign store_sent_o   = w_send &  req_is_store_i;

   // ------------------------------------------------------------------------
   // Pending-tag table
   // ------------------------------------------------------------------------
   dcache_tag_table #(
      .TID_WIDTH (TID_WIDTH)
   ) u_tag_table (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .set_i     (w_send),
      .set_tid_i (req_tid_i),
      .clr_i     (w_rsp_match),
      .clr_tid_i (dc_rsp_tid_i),
      .pending_o (w_pending)
   );

   // ------------------------------------------------------------------------
   // In-flight counter: a send and a matched response in the same cycle
   // cancel out.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_inflight <= '0;
      end else begin
         case ({w_send, w_rsp_match})
            2'b10:   r_inflight <= r_inflight + CNT_WIDTH'(1);
            2'b01:   r_inflight <= r_inflight - CNT_WIDTH'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Fence FSM. The ack is registered on the DRAIN->ACK transition so it is
   // high for exactly the one cycle spent in ACK. Drain completion uses the
   // registered count, so responses arriving this cycle count next cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= RUN;
         r_fence_ack <= 1'b0;
      end else begin
         r_fence_ack <= 1'b0;
         case (r_state)
            RUN: begin
               if (fence_req_i) r_state <= DRAIN;
            end
            DRAIN: begin
               if ((r_inflight == '0) && wbuf_empty_i) begin
                  r_state     <= ACK;
                  r_fence_ack <= 1'b1;
               end
            end
            ACK: begin
               r_state <= RUN;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign fence_ack_o = r_fence_ack;
   assign inflight_o  = r_inflight;
   assign busy_o      = (r_state != RUN) | (r_inflight != '0);

   // ------------------------------------------------------------------------
   // Orphan-response error flag
   // ------------------------------------------------------------------------
`ifdef DCACHE_REQ_TRACKER_ERR_EN
   logic r_err_orphan;
   logic w_rsp_orphan;

   assign w_rsp_orphan = dc_rsp_valid_i & ~w_pending[dc_rsp_tid_i];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_err_orphan <= 1'b0;
      end else if (w_rsp_orphan) begin
         r_err_orphan <= 1'b1;
      end
   end

   assign err_orphan_rsp_o = r_err_orphan;
`else
   assign err_orphan_rsp_o = 1'b0;
`endif

   // The counter and the table move together, so the count can never pass
   // the configured limit.
   a_inflight_bound : assert property (
      @(posedge clk_i) disable iff (!rstn_i)
         r_inflight <= CNT_WIDTH'(MAX_INFLIGHT)
   );

endmodule

// File: tb/tb_dcache_req_tracker.sv
// ----------------------------------------------------------------------------
// tb_dcache_req_tracker
// Self-checking bench. Instance "a" uses default parameters and is checked
// every cycle against a set-of-outstanding-tags model; instance "b" uses
// MAX_INFLIGHT=2 for the counter-limit scenario. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_dcache_req_tracker;

   localparam int TW = 7;

`ifdef DCACHE_REQ_TRACKER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance a (defaults) ----------------
   logic          a_req_valid = 0, a_req_is_store = 0, a_dc_req_ready = 0;
   logic [TW-1:0] a_req_tid = '0, a_rsp_tid = '0;
   logic          a_rsp_valid = 0, a_wbuf_empty = 1, a_fence_req = 0;
   logic          a_req_ready, a_dc_req_valid, a_fence_ack, a_busy;
   logic          a_load_sent, a_store_sent, a_err;
   logic [3:0]    a_inflight;

   dcache_req_tracker dut_a (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .req_valid_i      (a_req_valid),
      .req_tid_i        (a_req_tid),
      .req_is_store_i   (a_req_is_store),
      .req_ready_o      (a_req_ready),
      .dc_req_valid_o   (a_dc_req_valid),
      .dc_req_ready_i   (a_dc_req_ready),
      .dc_rsp_valid_i   (a_rsp_valid),
      .dc_rsp_tid_i     (a_rsp_tid),
      .wbuf_empty_i     (a_wbuf_empty),
      .fence_req_i      (a_fence_req),
      .fence_ack_o      (a_fence_ack),
      .inflight_o       (a_inflight),
      .busy_o           (a_busy),
      .load_sent_o      (a_load_sent),
      .store_sent_o     (a_store_sent),
      .err_orphan_rsp_o (a_err)
   );

   // ---------------- instance b (MAX_INFLIGHT=2) ----------------
   logic          b_req_valid = 0;
   logic [TW-1:0] b_req_tid = '0, b_rsp_tid = '0;
   logic          b_rsp_valid = 0;
   logic          b_req_ready, b_dc_req_valid, b_fence_ack, b_busy;
   logic          b_load_sent, b_store_sent, b_err;
   logic [1:0]    b_inflight;

   dcache_req_tracker #(.MAX_INFLIGHT(2)) dut_b (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .req_valid_i      (b_req_valid),
      .req_tid_i        (b_req_tid),
      .req_is_store_i   (1'b0),
      .req_ready_o      (b_req_ready),
      .dc_req_valid_o   (b_dc_req_valid),
      .dc_req_ready_i   (1'b1),
      .dc_rsp_valid_i   (b_rsp_valid),
      .dc_rsp_tid_i     (b_rsp_tid),
      .wbuf_empty_i     (1'b1),
      .fence_req_i      (1'b0),
      .fence_ack_o      (b_fence_ack),
      .inflight_o       (b_inflight),
      .busy_o           (b_busy),
      .load_sent_o      (b_load_sent),
      .store_sent_o     (b_store_sent),
      .err_orphan_rsp_o (b_err)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model for instance a ----------------
   // Outstanding requests are a set of tags; the in-flight count is its size.
   // Fence phase: 0 = running, 1 = draining, 2 = acknowledging.
   bit            m_pend [128];
   int            m_phase;
   bit            m_err;
   bit            m_send, m_match, m_orphan, m_fen, m_wbe;
   logic [TW-1:0] m_tid, m_rtid;
   logic [10:0]   e_vec;

   typedef struct packed {
      bit            rv;
      logic [TW-1:0] tid;
      bit            st;
      bit            dr;
      bit            rspv;
      logic [TW-1:0] rtid;
      bit            wbe;
      bit            fen;
   } stim_t;

   function automatic stim_t mk(bit rv, int tid, bit st, bit dr, bit rspv,
                                int rtid, bit wbe, bit fen);
      stim_t s;
      s.rv = rv; s.tid = TW'(tid); s.st = st; s.dr = dr;
      s.rspv = rspv; s.rtid = TW'(rtid); s.wbe = wbe; s.fen = fen;
      return s;
   endfunction

   function automatic int m_count();
      int c = 0;
      foreach (m_pend[i]) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic [10:0] obs_a();
      return {a_req_ready, a_dc_req_valid, a_load_sent, a_store_sent,
              a_busy, a_fence_ack, a_err, a_inflight};
   endfunction

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase = 0;
      m_err   = 1'b0;
   endtask

   // Apply one cycle of stimulus and predict this cycle's outputs.
   task automatic drive_a(input stim_t s);
      int cnt;
      bit issue, dcv;
      @(negedge clk);
      a_req_valid    = s.rv;
      a_req_tid      = s.tid;
      a_req_is_store = s.st;
      a_dc_req_ready = s.dr;
      a_rsp_valid    = s.rspv;
      a_rsp_tid      = s.rtid;
      a_wbuf_empty   = s.wbe;
      a_fence_req    = s.fen;
      #1;
      cnt      = m_count();
      issue    = (m_phase == 0) && !s.fen && !m_pend[s.tid] && (cnt < 8);
      dcv      = s.rv && issue;
      m_send   = dcv && s.dr;
      m_tid    = s.tid;
      m_rtid   = s.rtid;
      m_match  = s.rspv && m_pend[s.rtid];
      m_orphan = s.rspv && !m_pend[s.rtid];
      m_fen    = s.fen;
      m_wbe    = s.wbe;
      e_vec = {s.dr && issue, dcv, m_send && !s.st, m_send && s.st,
               (m_phase != 0) || (cnt != 0), m_phase == 2, m_err, 4'(cnt)};
   endtask

   // Advance the model across the rising edge.
   task automatic clock_a();
      int cnt;
      cnt = m_count();
      @(posedge clk);
      case (m_phase)
         0:       if (m_fen) m_phase = 1;
         1:       if (cnt == 0 && m_wbe) m_phase = 2;
         default: m_phase = 0;
      endcase
      if (m_match)  m_pend[m_rtid] = 1'b0;
      if (m_send)   m_pend[m_tid]  = 1'b1;
      if (m_orphan && ERR_EN) m_err = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      a_req_valid    = 1'b1;
      a_dc_req_ready = 1'b1;
      b_req_valid    = 1'b1;
      #1 rstn = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({a_req_ready, a_dc_req_valid, a_load_sent, a_store_sent, a_busy,
           a_fence_ack, a_err, a_inflight} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs_a: got %b expected all zero", obs_a());
      end
      checks++;
      if ({b_req_ready, b_dc_req_valid, b_busy, b_inflight} !== 5'd0) begin
         errors++;
         $display("FAIL reset_outputs_b: got %b expected 00000",
                  {b_req_ready, b_dc_req_valid, b_busy, b_inflight});
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_dup_tid();
      stim_t q[$];
      q.push_back(mk(1, 5, 0, 1, 0, 0, 1, 0));  // send tid 5
      q.push_back(mk(1, 5, 0, 1, 0, 0, 1, 0));  // blocked
      q.push_back(mk(1, 5, 0, 1, 0, 0, 1, 0));  // blocked
      q.push_back(mk(1, 5, 0, 1, 1, 5, 1, 0));  // rsp 5 same cycle: still blocked
      q.push_back(mk(1, 5, 0, 1, 0, 0, 1, 0));  // issued
      q.push_back(mk(0, 0, 0, 1, 1, 5, 1, 0));  // retire
      foreach (q[i]) begin
         drive_a(q[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL dup_tid step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         if (i >= 1 && i <= 3) begin
            checks++;
            if (a_req_ready !== 1'b0) begin
               errors++;
               $display("FAIL dup_tid_blocked step%0d: ready=%b expected 0", i, a_req_ready);
            end
         end
         if (i == 4) begin
            checks++;
            if (a_req_ready !== 1'b1) begin
               errors++;
               $display("FAIL dup_tid_reissue: ready=%b expected 1", a_req_ready);
            end
         end
         clock_a();
      end
   endtask

   task automatic test_max_inflight();
      bit rv [6];
      int tid [6];
      bit rsp [6];
      bit exp_rdy [6];
      int exp_inf [6];
      rv      = '{1, 1, 1, 1, 1, 0};
      tid     = '{1, 2, 3, 3, 3, 0};
      rsp     = '{0, 0, 0, 1, 0, 0};
      exp_rdy = '{1, 1, 0, 0, 1, 0};
      exp_inf = '{0, 1, 2, 2, 1, 2};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         b_req_valid = rv[i];
         b_req_tid   = TW'(tid[i]);
         b_rsp_valid = rsp[i];
         b_rsp_tid   = TW'(1);
         #1;
         checks++;
         if (b_req_ready !== exp_rdy[i]) begin
            errors++;
            $display("FAIL max_inflight_ready c%0d: got %b expected %b", i, b_req_ready, exp_rdy[i]);
         end
         checks++;
         if (b_inflight !== 2'(exp_inf[i])) begin
            errors++;
            $display("FAIL max_inflight_count c%0d: got %0d expected %0d", i, b_inflight, exp_inf[i]);
         end
      end
      // retire tids 2 and 3
      for (int i = 2; i <= 3; i++) begin
         @(negedge clk);
         b_req_valid = 1'b0;
         b_rsp_valid = 1'b1;
         b_rsp_tid   = TW'(i);
      end
      @(negedge clk);
      b_rsp_valid = 1'b0;
      #1;
      checks++;
      if (b_inflight !== 2'd0) begin
         errors++;
         $display("FAIL max_inflight_drained: got %0d expected 0", b_inflight);
      end
   endtask

   task automatic test_same_cycle();
      stim_t q[$];
      q.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0));
      q.push_back(mk(1, 2, 0, 1, 0, 0, 1, 0));
      q.push_back(mk(1, 3, 1, 1, 0, 0, 1, 0));
      q.push_back(mk(1, 4, 0, 1, 1, 1, 1, 0));  // send 4 + rsp 1 at count 3
      q.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0));
      q.push_back(mk(0, 0, 0, 1, 1, 3, 1, 0));
      q.push_back(mk(0, 0, 0, 1, 1, 4, 1, 0));
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
      foreach (q[i]) begin
         drive_a(q[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL same_cycle step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         if (i == 3 || i == 4) begin
            checks++;
            if (a_inflight !== 4'd3) begin
               errors++;
               $display("FAIL same_cycle_count step%0d: got %0d expected 3", i, a_inflight);
            end
         end
         clock_a();
      end
   endtask

   task automatic test_fence();
      stim_t q[$];
      q.push_back(mk(1, 10, 0, 1, 0, 0, 1, 0));  // 0 send 10
      q.push_back(mk(1, 11, 1, 1, 0, 0, 1, 0));  // 1 send 11
      q.push_back(mk(1, 12, 0, 1, 0, 0, 0, 1));  // 2 fence raised: no issue
      q.push_back(mk(1, 12, 0, 1, 0, 0, 0, 1));  // 3 draining
      q.push_back(mk(0, 0, 0, 1, 1, 10, 0, 1));  // 4 rsp 10
      q.push_back(mk(0, 0, 0, 1, 1, 11, 0, 1));  // 5 rsp 11
      q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));   // 6 empty but wbuf busy
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));   // 7 wbuf empty
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));   // 8 ack, requester drops fence
      q.push_back(mk(1, 12, 0, 1, 0, 0, 1, 0));  // 9 back to run
      q.push_back(mk(0, 0, 0, 1, 1, 12, 1, 0));  // 10 retire 12
      foreach (q[i]) begin
         drive_a(q[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL fence step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         if (i == 2 || i == 3) begin
            checks++;
            if (a_dc_req_valid !== 1'b0) begin
               errors++;
               $display("FAIL fence_no_issue step%0d: dc_req_valid=%b expected 0", i, a_dc_req_valid);
            end
         end
         if (i >= 2) begin
            checks++;
            if (a_fence_ack !== (i == 8)) begin
               errors++;
               $display("FAIL fence_ack step%0d: got %b expected %b", i, a_fence_ack, (i == 8));
            end
         end
         clock_a();
      end
   endtask

   task automatic test_orphan();
      stim_t q[$];
      q.push_back(mk(1, 20, 0, 1, 0, 0, 1, 0));  // send 20
      q.push_back(mk(0, 0, 0, 1, 1, 9, 1, 0));   // orphan rsp 9
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
      q.push_back(mk(0, 0, 0, 1, 1, 20, 1, 0));
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
      foreach (q[i]) begin
         drive_a(q[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL orphan step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         if (i == 2) begin
            checks++;
            if (a_inflight !== 4'd1) begin
               errors++;
               $display("FAIL orphan_count: got %0d expected 1", a_inflight);
            end
            checks++;
            if (a_err !== ERR_EN) begin
               errors++;
               $display("FAIL orphan_err: got %b expected %b", a_err, ERR_EN);
            end
         end
         clock_a();
      end
   endtask

   task automatic test_reset_drain();
      stim_t q[$];
      stim_t r[$];
      q.push_back(mk(1, 30, 0, 1, 0, 0, 1, 0));  // send 30
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));   // fence -> drain
      q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));   // draining, 30 still out
      foreach (q[i]) begin
         drive_a(q[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL reset_drain_pre step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         clock_a();
      end
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_tid   = TW'(30);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({a_busy, a_fence_ack, a_dc_req_valid, a_req_ready, a_inflight} !== 8'd0) begin
         errors++;
         $display("FAIL reset_drain_during: busy=%b ack=%b valid=%b ready=%b inflight=%0d expected all 0",
                  a_busy, a_fence_ack, a_dc_req_valid, a_req_ready, a_inflight);
      end
      a_req_valid = 1'b0;
      a_fence_req = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      r.push_back(mk(1, 30, 0, 1, 0, 0, 1, 0));  // tid 30 free again
      r.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
      r.push_back(mk(0, 0, 0, 1, 1, 30, 1, 0));
      r.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
      foreach (r[i]) begin
         drive_a(r[i]);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL reset_drain_post step%0d: got %b expected %b", i, obs_a(), e_vec);
         end
         checks++;
         if (a_fence_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_ack step%0d: got %b expected 0", i, a_fence_ack);
         end
         clock_a();
      end
   endtask

   task automatic test_random();
      bit fen = 1'b0;
      stim_t s;
      for (int c = 0; c < 400; c++) begin
         if (m_phase == 2) fen = 1'b0;
         else if (!fen && $urandom_range(0, 24) == 0) fen = 1'b1;
         s = mk($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, fen);
         drive_a(s);
         checks++;
         if (obs_a() !== e_vec) begin
            errors++;
            $display("FAIL random cyc%0d: got %b expected %b", c, obs_a(), e_vec);
         end
         clock_a();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_dup_tid();
      test_max_inflight();
      test_same_cycle();
      test_fence();
      test_orphan();
      test_reset_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
